imem_loader: RTL

Byte-serial instruction memory programmer: accepts a stream of bytes over a valid/ready handshake and assembles them into little-endian 32-bit words. Each complete word is written into the byte-addressed instruction memory through a single-cycle write port. The block is the write-side counterpart of the fetch-stage instruction memory read path. It sits between a host/debug byte source and the instruction memory, and holds the pipeline off (`busy`) while a program image loads.

---
 rtl/imem_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Byte-serial instruction memory programmer. It accepts a byte stream over a
// valid/ready handshake and assembles the bytes into little-endian 32-bit
// words. Each completed word goes to the instruction memory through a
// single-cycle write port at BASE_ADDR + 4*index.
//
// Parameters:
//   MEM_BYTES  instruction memory size in bytes (multiple of 4)
//   BASE_ADDR  byte address of the first word written (4-aligned)
//
// Optional feature macro:
//   IMEM_LOADER_CHECKSUM_EN  when defined, builds the running XOR checksum of
//                            written words. When undefined, o_checksum is
//                            tied to zero and no checksum flops exist.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_start        begin a load (sampled only in IDLE or DONE)
//   i_num_words    number of words to load, latched on accepted start
//   i_byte_in      stream byte
//   i_byte_valid   i_byte_in is valid
//   o_byte_ready   loader accepts a byte this cycle (decoded from state)
//   o_mem_we       one-cycle memory write strobe
//   o_mem_addr     byte address of the word being written
//   o_mem_wdata    word; [7:0] lands at o_mem_addr+0, [31:24] at +3
//   o_busy         load in progress (COLLECT or WRITE)
//   o_done         load finished; held until next accepted start or reset
//   o_err          num_words exceeded capacity; held like o_done
//   o_checksum     XOR of all words written this load
//   o_dbg_state    current FSM state encoding, for debug and checkers
//
// Handshake: a byte transfers on a rising edge where both i_byte_valid and
// o_byte_ready are high. The source must hold i_byte_in stable while
// i_byte_valid is high and no transfer has happened yet. Dropping
// i_byte_valid between bytes is allowed; the byte position holds.
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int MEM_BYTES = 192,
    parameter int BASE_ADDR = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [5:0]  i_num_words,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_checksum,
    output logic [1:0]  o_dbg_state
);

    // Number of words that fit between BASE_ADDR and the end of memory.
    localparam logic [31:0] CAP_W  = 32'((MEM_BYTES - BASE_ADDR) / 4);
    localparam logic [31:0] BASE_W = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_eff;
    logic [5:0]  r_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_asm;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_start_ok;
    logic        w_over;
    logic [5:0]  w_eff;

    assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_over     = ({26'd0, i_num_words} > CAP_W);
    // When num_words exceeds capacity the capacity itself fits in 6 bits,
    // so the truncation below only ever sees values that already fit.
    assign w_eff      = w_over ? CAP_W[5:0] : i_num_words;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_eff       <= '0;
            r_idx       <= '0;
            r_byte_cnt  <= '0;
            r_asm       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_W;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_eff      <= w_eff;
                        r_err      <= w_over;
                        r_idx      <= '0;
                        r_byte_cnt <= '0;
                        r_asm      <= '0;
                        if (w_eff == 6'd0) begin
                            // Nothing to load: finish immediately.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_COLLECT;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (i_byte_valid) begin
                        if (r_byte_cnt == 2'd3) begin
                            // Fourth byte: the word is complete, and the
                            // write strobe/address/data are registered so
                            // they appear together in the WRITE cycle.
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= BASE_W + {24'd0, r_idx, 2'b00};
                            r_mem_wdata <= {i_byte_in, r_asm};
                            r_byte_cnt  <= 2'd0;
                            r_state     <= S_WRITE;
                        end else begin
                            r_asm[{r_byte_cnt, 3'b000} +: 8] <= i_byte_in;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end

                S_WRITE: begin
                    r_mem_we <= 1'b0;
                    r_idx    <= r_idx + 6'd1;
                    if ((r_idx + 6'd1) == r_eff) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_COLLECT;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Folds in the word during its WRITE cycle, so the updated value is
    // visible from the cycle after the write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (r_state == S_WRITE) begin
            r_checksum <= r_checksum ^ r_mem_wdata;
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = 32'h0;
`endif

    assign o_byte_ready = (r_state == S_COLLECT);
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_dbg_state  = r_state;

endmodule
